// File: rtl/ov7670_stream_gen_if.sv
// OV7670 camera-side pixel bus: emulated pclk, frame/line syncs and data byte.
// The sensor side drives through master; a capture block listens through slave.
interface ov7670_stream_gen_if;
   logic       pclk;
   logic       vsync;
   logic       href;
   logic [7:0] d;

   modport master (output pclk, output vsync, output href, output d);
   modport slave  (input  pclk, input  vsync, input  href, input  d);
endinterface

// File: rtl/ov7670_stream_gen.sv
// OV7670 emulator: VGA-style frame timing with RGB444 test patterns.
// Optional per-frame CRC-16-CCITT of active bytes when STREAM_CRC_EN is defined.
module ov7670_stream_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 144,
   parameter int V_SYNC   = 3,
   parameter int V_BACK   = 17,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [1:0]           pattern_sel,
   input  logic [11:0]          solid_rgb,
   ov7670_stream_gen_if.master  cam,
   output logic                 frame_done,
   output logic [15:0]          frame_count,
   output logic [15:0]          frame_crc
);

   localparam int L  = 2 * (H_ACTIVE + H_BLANK);
   localparam int LF = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam logic [15:0] COL_LAST  = 16'(L - 1);
   localparam logic [15:0] LINE_LAST = 16'(LF - 1);
   localparam logic [15:0] Y0        = 16'(V_SYNC + V_BACK);
   localparam logic [15:0] Y1        = 16'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [15:0] VS        = 16'(V_SYNC);
   localparam logic [15:0] HA2       = 16'(2 * H_ACTIVE);
   localparam logic [15:0] BW_LAST   = 16'(H_ACTIVE / 8 - 1);
   localparam logic [5:0]  Y0_6      = 6'(V_SYNC + V_BACK);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t      r_state;
   logic        r_pclk, r_vsync, r_href, r_done;
   logic [7:0]  r_d;
   logic [15:0] r_col, r_line, r_bcnt, r_fcount;
   logic [2:0]  r_bar;
   logic [1:0]  r_pat;
   logic [11:0] r_solid;

   logic        w_last, w_start, w_stop, w_adv, w_run;
   logic [15:0] w_ncol, w_nline, w_nbcnt;
   logic [2:0]  w_nbar;
   logic [1:0]  w_pat;
   logic [11:0] w_solid;
   logic [9:0]  w_x;
   logic [5:0]  w_y;
   logic [3:0]  w_r, w_g, w_b;
   logic        w_vsync, w_href;
   logic [7:0]  w_byte;

   always_comb begin
      w_last  = (r_state == S_RUN) && (r_col == COL_LAST) && (r_line == LINE_LAST);
      w_start = r_pclk && enable && ((r_state == S_IDLE) || w_last);
      w_stop  = r_pclk && w_last && !enable;
      w_adv   = r_pclk && (r_state == S_RUN) && !w_last;
      w_run   = w_start || w_adv;
      w_ncol  = 16'd0;
      w_nline = 16'd0;
      if (w_adv) begin
         if (r_col == COL_LAST) begin
            w_nline = r_line + 16'd1;
         end else begin
            w_ncol  = r_col + 16'd1;
            w_nline = r_line;
         end
      end
      // Bar index tracked incrementally, restarting at every line start
      w_nbar  = 3'd0;
      w_nbcnt = 16'd0;
      if (w_adv && (w_ncol != 16'd0)) begin
         w_nbar  = r_bar;
         w_nbcnt = r_bcnt;
         if (!w_ncol[0]) begin
            if (r_bcnt == BW_LAST) begin
               w_nbcnt = 16'd0;
               w_nbar  = r_bar + 3'd1;
            end else begin
               w_nbcnt = r_bcnt + 16'd1;
            end
         end
      end
      w_pat   = w_start ? pattern_sel : r_pat;
      w_solid = w_start ? solid_rgb : r_solid;
      w_x     = w_ncol[10:1];
      w_y     = w_nline[5:0] - Y0_6;
      w_r     = 4'h0;
      w_g     = 4'h0;
      w_b     = 4'h0;
      unique case (w_pat)
         2'd0: begin
            w_r = {4{~w_nbar[2]}};
            w_g = {4{~w_nbar[1]}};
            w_b = {4{~w_nbar[0]}};
         end
         2'd1: begin
            w_r = w_x[9:6];
            w_g = w_x[9:6];
            w_b = w_x[9:6];
         end
         2'd2: {w_r, w_g, w_b} = (w_x[5] ^ w_y[5]) ? 12'hFFF : 12'h000;
         2'd3: {w_r, w_g, w_b} = w_solid;
      endcase
      w_vsync = w_run && (w_nline < VS);
      w_href  = w_run && (w_nline >= Y0) && (w_nline < Y1) && (w_ncol < HA2);
      w_byte  = 8'h00;
      if (w_href) w_byte = w_ncol[0] ? {w_g, w_b} : {4'h0, w_r};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_pclk   <= 1'b0;
         r_vsync  <= 1'b0;
         r_href   <= 1'b0;
         r_d      <= 8'h00;
         r_done   <= 1'b0;
         r_col    <= 16'd0;
         r_line   <= 16'd0;
         r_bcnt   <= 16'd0;
         r_bar    <= 3'd0;
         r_pat    <= 2'd0;
         r_solid  <= 12'h000;
         r_fcount <= 16'd0;
      end else begin
         r_pclk <= ~r_pclk;
         r_done <= 1'b0;
         if (w_run || w_stop) begin
            r_state <= w_run ? S_RUN : S_IDLE;
            r_col   <= w_ncol;
            r_line  <= w_nline;
            r_bcnt  <= w_nbcnt;
            r_bar   <= w_nbar;
            r_vsync <= w_vsync;
            r_href  <= w_href;
            r_d     <= w_byte;
         end
         if (w_start) begin
            r_pat   <= pattern_sel;
            r_solid <= solid_rgb;
         end
         if (r_pclk && w_last) begin
            r_done   <= 1'b1;
            r_fcount <= r_fcount + 16'd1;
         end
      end
   end

   assign cam.pclk    = r_pclk;
   assign cam.vsync   = r_vsync;
   assign cam.href    = r_href;
   assign cam.d       = r_d;
   assign frame_done  = r_done;
   assign frame_count = r_fcount;

`ifdef STREAM_CRC_EN
   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] v;
      v = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) v = v[15] ? ((v << 1) ^ 16'h1021) : (v << 1);
      return v;
   endfunction

   logic [15:0] r_crc, r_fcrc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_crc  <= 16'h0000;
         r_fcrc <= 16'h0000;
      end else begin
         if (w_start) r_crc <= w_href ? crc_byte(16'hFFFF, w_byte) : 16'hFFFF;
         else if (w_adv && w_href) r_crc <= crc_byte(r_crc, w_byte);
         if (r_pclk && w_last) r_fcrc <= r_crc;
      end
   end

   assign frame_crc = r_fcrc;
`else
   assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen with a 16/4/1/1/4/1 geometry.
// Frame: 7 lines x 40 bytes = 280 fall edges = 560 clks.
module tb_ov7670_stream_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic [11:0] solid_rgb = 12'h000;
   logic        frame_done;
   logic [15:0] frame_count, frame_crc;

   int checks = 0;
   int errors = 0;
   int cyc = 0, fd_cnt = 0, fd_last = 0, fd_gap = 0;

   logic [15:0] bar_tab [8] = '{16'h0FFF, 16'h0FF0, 16'h0F0F, 16'h0F00,
                                16'h00FF, 16'h00F0, 16'h000F, 16'h0000};

   ov7670_stream_gen_if cam ();

   ov7670_stream_gen #(
      .H_ACTIVE(16), .H_BLANK(4), .V_SYNC(1),
      .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
      .cam(cam), .frame_done(frame_done),
      .frame_count(frame_count), .frame_crc(frame_crc)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (frame_done === 1'b1) begin
         fd_cnt  <= fd_cnt + 1;
         fd_gap  <= cyc - fd_last;
         fd_last <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] v;
      logic fb;
      v = c;
      for (int i = 7; i >= 0; i--) begin
         fb = v[15] ^ b[i];
         v = {v[14:0], 1'b0};
         if (fb) v = v ^ 16'h1021;
      end
      return v;
   endfunction

   // Advance to the negedge right after the next pclk 1->0 transition
   task automatic step_fall();
      @(negedge clk);
      if (cam.pclk !== 1'b0) @(negedge clk);
   endtask

   task automatic frame_step(input string tag, input bit bars, input logic [15:0] pair,
                             input int act_at, input int act, input logic [15:0] exp_cnt);
      int vs_n = 0, hr_rise = 0, shape_err = 0, data_err = 0, fd_mid = 0;
      logic prev = 1'b0;
      logic [15:0] cm = 16'hFFFF;
      logic [15:0] tp;
      logic [7:0] de;
      logic he;
      for (int k = 0; k < 280; k++) begin
         int ln, cl;
         ln = k / 40;
         cl = k % 40;
         he = (ln >= 2) && (ln < 6) && (cl < 32);
         de = 8'h00;
         if (he) begin
            tp = bars ? bar_tab[cl / 4] : pair;
            de = (cl % 2 == 1) ? tp[7:0] : tp[15:8];
            cm = crc_ref(cm, de);
         end
         if (cam.vsync === 1'b1) vs_n++;
         if (cam.vsync !== (ln == 0)) shape_err++;
         if (cam.href !== he) shape_err++;
         if (cam.href === 1'b1 && !prev) hr_rise++;
         prev = cam.href;
         if (cam.d !== de) data_err++;
         if (k > 0 && frame_done !== 1'b0) fd_mid++;
         if (k == act_at) begin
            case (act)
               1: begin pattern_sel = 2'd3; solid_rgb = 12'hA5C; end
               2: solid_rgb = 12'h123;
               3: enable = 1'b0;
               default: ;
            endcase
         end
         step_fall();
      end
      chk({tag, "_vsync_n"}, vs_n, 40);
      chk({tag, "_href_pulses"}, hr_rise, 4);
      chk({tag, "_shape"}, shape_err, 0);
      chk({tag, "_data"}, data_err, 0);
      chk({tag, "_fd_mid"}, fd_mid, 0);
      chk({tag, "_fd_end"}, frame_done, 1);
      chk({tag, "_count"}, frame_count, exp_cnt);
`ifdef STREAM_CRC_EN
      chk({tag, "_crc"}, frame_crc, cm);
`else
      chk({tag, "_crc"}, frame_crc, 16'h0000);
`endif
   endtask

   initial begin
      int bad;
      int fd0;
      logic [15:0] crc_zero;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_outs",
             {cam.pclk, cam.vsync, cam.href, cam.d, frame_done, frame_count, frame_crc},
             32'd0);
      end
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("pclk_toggle", cam.pclk, (i % 2 == 0) ? 1 : 0);
      end
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if ({cam.vsync, cam.href, cam.d} !== 10'd0) bad++;
      end
      chk("idle_quiet", bad, 0);

      enable = 1'b1;
      pattern_sel = 2'd0;
      step_fall();
      chk("first_vsync", cam.vsync, 1);
      frame_step("A_bars", 1'b1, 16'h0000, 150, 1, 16'd1);
      frame_step("B_solid", 1'b0, 16'h0A5C, 100, 2, 16'd2);
      frame_step("C_drop", 1'b0, 16'h0123, 130, 3, 16'd3);
      chk("C_idle_vsync", cam.vsync, 0);

      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ({cam.vsync, cam.href, cam.d} !== 10'd0) bad++;
      end
      chk("post_stop_quiet", bad, 0);
      chk("fd_pulses", fd_cnt, 3);
      chk("fd_period", fd_gap, 560);

      solid_rgb = 12'h000;
      step_fall();
      enable = 1'b1;
      step_fall();
      chk("restart_vsync", cam.vsync, 1);
      frame_step("D_zero", 1'b0, 16'h0000, -1, 0, 16'd4);
      frame_step("E_zero", 1'b0, 16'h0000, -1, 0, 16'd5);
      crc_zero = 16'hFFFF;
      for (int i = 0; i < 128; i++) crc_zero = crc_ref(crc_zero, 8'h00);
`ifdef STREAM_CRC_EN
      chk("zero_crc_ref", frame_crc, crc_zero);
`else
      chk("zero_crc_off", frame_crc, 16'h0000);
`endif

      for (int i = 0; i < 90; i++) step_fall();
      @(negedge clk);
      fd0 = fd_cnt;
      reset = 1'b1;
      @(negedge clk);
      chk("midreset_outs",
          {cam.pclk, cam.vsync, cam.href, cam.d, frame_done, frame_count, frame_crc},
          32'd0);
      reset = 1'b0;
      enable = 1'b0;
      repeat (4) @(negedge clk);
      chk("midreset_no_fd", fd_cnt, fd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
